// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter for the LC-3b pipeline: merges IF fetches
// and MEM-stage loads/stores onto a single physical memory port, one access per grant.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_request,
    input  logic [15:0] inst_address,
    output logic [15:0] inst_rdata,
    output logic        inst_response,

    input  logic        data_request,
    input  logic [15:0] data_address,
    input  logic        write_enable,
    input  logic [15:0] data_wdata,
    input  logic [1:0]  data_byte_enable,
    output logic [15:0] data_rdata,
    output logic        data_response,

    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;
    logic        r_write;

    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_busy;

    // Data wins a tie only when the previous grant went to inst, so ties alternate.
    always_comb begin
        w_state_next = r_state;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_request && (!inst_request || !r_last_grant)) begin
                    w_grant_data = 1'b1;
                    w_state_next = DATA;
                end else if (inst_request) begin
                    w_grant_inst = 1'b1;
                    w_state_next = INST;
                end
            end
            INST, DATA: begin
                if (pmem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_be         <= 2'b00;
            r_write      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_data) begin
                r_last_grant <= 1'b1;
                r_addr       <= data_address;
                r_wdata      <= data_wdata;
                r_be         <= data_byte_enable;
                r_write      <= write_enable;
            end else if (w_grant_inst) begin
                r_last_grant <= 1'b0;
                r_addr       <= inst_address;
                r_wdata      <= 16'h0000;
                r_be         <= 2'b11;
                r_write      <= 1'b0;
            end
        end
    end

    // All physical outputs decode from state, so an async reset drops them at once.
    assign w_busy           = (r_state != IDLE);
    assign pmem_read        = (r_state == INST) || ((r_state == DATA) && !r_write);
    assign pmem_write       = (r_state == DATA) && r_write;
    assign pmem_address     = w_busy ? r_addr : 16'h0000;
    assign pmem_wdata       = pmem_write ? r_wdata : 16'h0000;
    assign pmem_byte_enable = pmem_write ? r_be : (pmem_read ? 2'b11 : 2'b00);

    assign inst_response    = (r_state == INST) && pmem_resp;
    assign data_response    = (r_state == DATA) && pmem_resp;
    assign inst_rdata       = inst_response ? pmem_rdata : 16'h0000;
    assign data_rdata       = data_response ? pmem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester tasks push expected accesses into per-side queues,
// a negedge monitor pops them at each grant and checks the physical port and responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_request;
    logic [15:0] inst_address;
    logic [15:0] inst_rdata;
    logic        inst_response;
    logic        data_request;
    logic [15:0] data_address;
    logic        write_enable;
    logic [15:0] data_wdata;
    logic [1:0]  data_byte_enable;
    logic [15:0] data_rdata;
    logic        data_response;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_request(inst_request), .inst_address(inst_address),
        .inst_rdata(inst_rdata), .inst_response(inst_response),
        .data_request(data_request), .data_address(data_address),
        .write_enable(write_enable), .data_wdata(data_wdata),
        .data_byte_enable(data_byte_enable), .data_rdata(data_rdata),
        .data_response(data_response),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [1:0]  be;
    } txn_t;

    txn_t        iq[$];
    txn_t        dq[$];
    bit          grant_log[$];
    logic [15:0] phys_mem[int];
    logic [15:0] ref_mem[int];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] seed(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed(a);
    endfunction

    // ---------------- memory responder ----------------
    int          mem_delay = -1;
    bit          mem_auto  = 1'b1;
    bit          man_resp  = 1'b0;
    logic [15:0] man_rdata = 16'h0000;
    int          wait_cnt  = -1;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (!mem_auto) begin
                pmem_resp  = man_resp;
                pmem_rdata = man_rdata;
                wait_cnt   = -1;
            end else if (pmem_resp) begin
                pmem_resp  = 1'b0;
                pmem_rdata = 16'h0000;
            end else if (reset || !(pmem_read || pmem_write)) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt < 0)
                    wait_cnt = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        phys_mem[int'(pmem_address)] = merge(
                            phys_mem.exists(int'(pmem_address)) ? phys_mem[int'(pmem_address)]
                                                                : seed(pmem_address),
                            pmem_wdata, pmem_byte_enable);
                        pmem_rdata = 16'($urandom);
                    end else begin
                        pmem_rdata = phys_mem.exists(int'(pmem_address)) ?
                                     phys_mem[int'(pmem_address)] : seed(pmem_address);
                    end
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cur_side = -1;
    txn_t        cur;
    bit          model_last = 1'b0;
    bit          prev_valid = 1'b0;
    bit          p_strobe, p_resp, p_ireq, p_dreq;
    bit          strobe, win, exp_done, exp_ir, exp_dr;
    logic [15:0] exp_val;
    int          strobe_cycles = 0;
    int          last_cycles = 0;
    int          resp_cnt[2] = '{0, 0};

    always @(negedge clk) begin
        if (reset) begin
            cur_side   = -1;
            model_last = 1'b0;
            prev_valid = 1'b0;
        end else begin
            strobe = pmem_read | pmem_write;
            if (prev_valid)
                chk("strobe_seq", 64'(strobe), 64'(p_strobe ? !p_resp : (p_ireq | p_dreq)));
            if (strobe && prev_valid && !p_strobe) begin
                // Expected winner from the arbitration rule applied to the sampled requests.
                win        = (p_ireq && p_dreq) ? !model_last : p_dreq;
                model_last = win;
                grant_log.push_back(win);
                chk("grant_has_request", 64'(win ? dq.size() : iq.size()) != 0, 64'(1));
                if (win ? (dq.size() != 0) : (iq.size() != 0)) begin
                    cur      = win ? dq.pop_front() : iq.pop_front();
                    cur_side = win ? 1 : 0;
                end
                strobe_cycles = 0;
            end
            if (strobe && cur_side >= 0) begin
                strobe_cycles++;
                chk("pmem_fields",
                    {pmem_read, pmem_write, pmem_address, pmem_byte_enable,
                     (cur.we ? pmem_wdata : 16'h0000)},
                    {!cur.we, cur.we, cur.addr, (cur.we ? cur.be : 2'b11),
                     (cur.we ? cur.wdata : 16'h0000)});
            end
            exp_done = strobe && pmem_resp && (cur_side >= 0);
            exp_ir   = exp_done && (cur_side == 0);
            exp_dr   = exp_done && (cur_side == 1);
            exp_val  = 16'h0000;
            if (exp_done) exp_val = cur.we ? pmem_rdata : ref_read(cur.addr);
            chk("inst_resp", {inst_response, inst_rdata}, {exp_ir, (exp_ir ? exp_val : 16'h0000)});
            chk("data_resp", {data_response, data_rdata}, {exp_dr, (exp_dr ? exp_val : 16'h0000)});
            if (exp_done) begin
                if (cur.we) ref_mem[int'(cur.addr)] = merge(ref_read(cur.addr), cur.wdata, cur.be);
                resp_cnt[cur_side]++;
                last_cycles = strobe_cycles;
                cur_side    = -1;
            end
            p_strobe   = strobe;
            p_resp     = pmem_resp;
            p_ireq     = inst_request;
            p_dreq     = data_request;
            prev_valid = 1'b1;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic wait_resp(input bit side, output logic [15:0] rd);
        int n = 0;
        rd = 16'h0000;
        do begin
            @(negedge clk);
            n++;
        end while (!(side ? data_response : inst_response) && n < 200);
        if (n >= 200) chk(side ? "data_timeout" : "inst_timeout", 64'(1), 64'(0));
        else rd = side ? data_rdata : inst_rdata;
    endtask

    task automatic do_inst(input logic [15:0] a, input bit hold, output logic [15:0] rd);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.wdata = 16'h0000; t.be = 2'b11;
        iq.push_back(t);
        inst_address = a;
        inst_request = 1'b1;
        wait_resp(1'b0, rd);
        $display("inst  addr=%h rdata=%h", a, rd);
        @(posedge clk); #1;
        if (!hold) inst_request = 1'b0;
    endtask

    task automatic do_data(input logic [15:0] a, input logic we, input logic [15:0] wd,
                           input logic [1:0] be, input bit hold, output logic [15:0] rd);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = wd; t.be = be;
        dq.push_back(t);
        data_address     = a;
        write_enable     = we;
        data_wdata       = wd;
        data_byte_enable = be;
        data_request     = 1'b1;
        wait_resp(1'b1, rd);
        $display("data  addr=%h we=%0d wdata=%h be=%b rdata=%h", a, we, wd, be, rd);
        @(posedge clk); #1;
        if (!hold) data_request = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        iq.delete();
        dq.delete();
        reset = 1'b0;
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        phys_mem[int'(a)] = v;
        ref_mem[int'(a)]  = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    logic [15:0] rd;
    int          c0;
    int          n;

    initial begin
        reset = 1'b1;
        inst_request = 1'b0; inst_address = 16'h0000;
        data_request = 1'b0; data_address = 16'h0000; write_enable = 1'b0;
        data_wdata = 16'h0000; data_byte_enable = 2'b00;
        @(negedge clk);
        chk("reset_outputs",
            {inst_rdata, inst_response, data_rdata, data_response, pmem_read, pmem_write,
             pmem_address, pmem_wdata, pmem_byte_enable}, 64'(0));
        do_reset();

        // Single fetch with a 2-cycle memory delay.
        mem_delay = 2;
        set_mem(16'h3000, 16'h1234);
        do_inst(16'h3000, 1'b0, rd);
        chk("fetch_rdata", 64'(rd), 64'h1234);
        chk("fetch_strobe_cycles", 64'(last_cycles), 64'(3));

        // Byte store to the high byte.
        mem_delay = 0;
        do_data(16'h4001, 1'b1, 16'hAB00, 2'b10, 1'b0, rd);
        chk("store_one_cycle", 64'(last_cycles), 64'(1));

        // Both requesting from reset: D, I, D.
        do_reset();
        grant_log.delete();
        fork
            begin
                do_data(16'h4010, 1'b0, 16'h0000, 2'b11, 1'b1, rd);
                do_data(16'h4012, 1'b0, 16'h0000, 2'b11, 1'b0, rd);
            end
            begin
                do_inst(16'h3100, 1'b0, rd);
            end
        join
        chk("alt_grant_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3)
            chk("alt_grant_order", {61'h0, grant_log[0], grant_log[1], grant_log[2]}, 64'b101);

        // LDI: pointer fetch then indirect read at the returned address.
        mem_delay = 1;
        set_mem(16'h5000, 16'h6000);
        set_mem(16'h6000, 16'hBEEF);
        c0 = resp_cnt[1];
        do_data(16'h5000, 1'b0, 16'h0000, 2'b11, 1'b1, rd);
        chk("ldi_pointer", 64'(rd), 64'h6000);
        do_data(rd, 1'b0, 16'h0000, 2'b11, 1'b0, rd);
        chk("ldi_value", 64'(rd), 64'hBEEF);
        chk("ldi_resp_count", 64'(resp_cnt[1] - c0), 64'(2));

        // Reset asserted mid-access; a late pmem_resp must be ignored.
        mem_auto  = 1'b0;
        man_resp  = 1'b0;
        man_rdata = 16'h7777;
        begin
            txn_t t;
            t.addr = 16'h4020; t.we = 1'b0; t.wdata = 16'h0000; t.be = 2'b11;
            dq.push_back(t);
        end
        data_address = 16'h4020; write_enable = 1'b0; data_request = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
        chk("rst_test_grant", 64'(pmem_read), 64'(1));
        #1 reset = 1'b1;
        #1 chk("rst_async_strobe", {pmem_read, pmem_write}, 64'(0));
        data_request = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        dq.delete();
        @(negedge clk);
        man_resp = 1'b1;
        @(negedge clk);
        chk("rst_late_resp", {data_response, data_rdata, inst_response}, 64'(0));
        man_resp = 1'b0;
        @(posedge clk); #2;
        mem_auto = 1'b1;
        $display("reset mid-access checked");

        // Fetch request dropped one cycle after grant still completes once.
        mem_delay = 2;
        c0 = resp_cnt[0];
        begin
            txn_t t;
            t.addr = 16'h3200; t.we = 1'b0; t.wdata = 16'h0000; t.be = 2'b11;
            iq.push_back(t);
        end
        @(posedge clk); #1;
        inst_address = 16'h3200; inst_request = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
        @(posedge clk); #1;
        inst_request = 1'b0;
        inst_address = 16'hFFFF;
        repeat (8) @(negedge clk);
        chk("drop_resp_count", 64'(resp_cnt[0] - c0), 64'(1));
        chk("drop_idle", {pmem_read, pmem_write}, 64'(0));
        $display("dropped request checked");

        // Randomized concurrent traffic.
        mem_delay = -1;
        fork
            begin
                automatic int gap_next = int'($urandom_range(0, 2));
                automatic int gap;
                automatic logic [15:0] rdi;
                for (int k = 0; k < 40; k++) begin
                    gap = gap_next;
                    gap_next = int'($urandom_range(0, 2));
                    repeat (gap) begin @(posedge clk); #1; end
                    do_inst(16'($urandom), (k < 39) && (gap_next == 0), rdi);
                end
            end
            begin
                automatic int gap_next = int'($urandom_range(0, 2));
                automatic int gap;
                automatic logic [15:0] rdd;
                automatic logic we;
                for (int k = 0; k < 40; k++) begin
                    gap = gap_next;
                    gap_next = int'($urandom_range(0, 2));
                    we = 1'($urandom_range(0, 1));
                    repeat (gap) begin @(posedge clk); #1; end
                    do_data(16'h4000 + 16'(2 * $urandom_range(0, 7)), we, 16'($urandom),
                            we ? 2'($urandom_range(1, 3)) : 2'b11,
                            (k < 39) && (gap_next == 0), rdd);
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(iq.size() + dq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
